// File: rtl/tdc_edge_if.sv
// Event stream from the TDC edge encoder: one first-transition event per handshake.
interface tdc_edge_if #(
  parameter int POS_W = 7
);
  logic             m_valid;
  logic             m_ready;
  logic [POS_W-1:0] m_pos;
  logic             m_rising;
  logic             m_multi;

  modport master (
    output m_valid,
    output m_pos,
    output m_rising,
    output m_multi,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_pos,
    input  m_rising,
    input  m_multi,
    output m_ready
  );
endinterface

// File: rtl/tdc_edge_encoder.sv
// Carry-chain TDC back end: registers the thermometer word, removes single-bit bubbles and
// encodes the first transition into a bin index, polarity and multi-edge flag on a valid/ready stream.
module tdc_edge_encoder #(
  parameter int WIDTH  = 100,
  parameter int POS_W  = $clog2(WIDTH + 1),
  parameter int DROP_W = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [WIDTH:0]    tdc_data,
  input  logic              en,
  tdc_edge_if.master        m,
  output logic [DROP_W-1:0] drop_cnt
);

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (&v) ? v : v + DROP_W'(1);
  endfunction

  logic [WIDTH:0]   r_p0;
  logic [WIDTH:0]   f_p1;
  logic [WIDTH:0]   filt_c;
  logic [WIDTH-1:0] diff_c;
  logic             hit_c;
  logic             multi_c;
  logic             rising_c;
  logic [POS_W-1:0] pos_c;
  logic             new_ev_c;

  // Stage 1 -> 2: end taps have only one neighbour, so they pass through unfiltered
  always_comb begin
    filt_c = r_p0;
    for (int i = 1; i < WIDTH; i++) begin
      filt_c[i] = maj3(r_p0[i-1], r_p0[i], r_p0[i+1]);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_p0 <= '0;
      f_p1 <= '0;
    end else begin
      r_p0 <= tdc_data;
      f_p1 <= filt_c;
    end
  end

  // Stage 2 -> 3: bit k of diff_c marks a transition between taps k and k+1
  assign diff_c   = f_p1[WIDTH:1] ^ f_p1[WIDTH-1:0];
  assign hit_c    = |diff_c;
  assign multi_c  = |(diff_c & (diff_c - WIDTH'(1)));
  assign new_ev_c = hit_c & en;

  always_comb begin
    pos_c    = '0;
    rising_c = 1'b0;
    for (int i = WIDTH; i >= 1; i--) begin
      if (f_p1[i] != f_p1[i-1]) begin
        pos_c    = POS_W'(i);
        rising_c = f_p1[i-1];
      end
    end
  end

  // Output register: a held event is never overwritten while the consumer stalls
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m.m_valid  <= 1'b0;
      m.m_pos    <= '0;
      m.m_rising <= 1'b0;
      m.m_multi  <= 1'b0;
      drop_cnt   <= '0;
    end else if (new_ev_c) begin
      if (!m.m_valid || m.m_ready) begin
        m.m_valid  <= 1'b1;
        m.m_pos    <= pos_c;
        m.m_rising <= rising_c;
        m.m_multi  <= multi_c;
      end else begin
        drop_cnt <= sat_inc(drop_cnt);
      end
    end else if (m.m_valid && m.m_ready) begin
      m.m_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tdc_edge_encoder.sv
// Bench for tdc_edge_encoder: directed scenarios plus random words against a behavioural model.
module tb_tdc_edge_encoder;
  localparam int WIDTH   = 100;
  localparam int POS_W   = 7;
  localparam int DROP_W  = 16;
  localparam int SDROP_W = 4;

  logic               clk = 1'b0;
  logic               resetn;
  logic [WIDTH:0]     tdc_data;
  logic               en;
  logic [DROP_W-1:0]  drop_cnt;
  logic [SDROP_W-1:0] drop_small;

  tdc_edge_if #(.POS_W(POS_W)) bus ();
  tdc_edge_if #(.POS_W(POS_W)) bus_s ();

  tdc_edge_encoder #(.WIDTH(WIDTH), .POS_W(POS_W), .DROP_W(DROP_W)) dut (
    .clk(clk), .resetn(resetn), .tdc_data(tdc_data), .en(en), .m(bus), .drop_cnt(drop_cnt)
  );

  tdc_edge_encoder #(.WIDTH(WIDTH), .POS_W(POS_W), .DROP_W(SDROP_W)) dut_small (
    .clk(clk), .resetn(resetn), .tdc_data(tdc_data), .en(en), .m(bus_s), .drop_cnt(drop_small)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [WIDTH:0]     s1, s2;
  logic               exp_valid, exp_rising, exp_multi;
  logic [POS_W-1:0]   exp_pos;
  logic [DROP_W-1:0]  exp_drop;
  logic               s_valid;
  logic [SDROP_W-1:0] s_drop;

  function automatic logic [WIDTH:0] thermo(input int lo, input int hi);
    logic [WIDTH:0] t;
    for (int i = 0; i <= WIDTH; i++) t[i] = (i >= lo) && (i <= hi);
    return t;
  endfunction

  function automatic logic [25:0] pack_out(input logic v, input logic [POS_W-1:0] p,
                                           input logic r, input logic mu, input logic [DROP_W-1:0] d);
    return {v, (v ? {p, r, mu} : 9'b0), d};
  endfunction

  function automatic logic [WIDTH:0] rand_word();
    logic [WIDTH:0] w;
    int a, b, k;
    a = $urandom_range(0, WIDTH + 1);
    b = $urandom_range(0, WIDTH + 1);
    for (int i = 0; i <= WIDTH; i++) w[i] = (i >= a) ^ (i >= b);
    if ($urandom_range(0, 1) == 1) w = ~w;
    if ($urandom_range(0, 3) == 0) begin
      k = $urandom_range(0, WIDTH);
      w[k] = ~w[k];
    end
    return w;
  endfunction

  // Majority-vote interior taps by counting ones, then list every transition.
  task automatic filter_encode(input logic [WIDTH:0] w, output logic hit, output logic [POS_W-1:0] pos,
                               output logic rising, output logic multi);
    logic [WIDTH:0] f;
    int n, first;
    for (int i = 0; i <= WIDTH; i++) begin
      if (i == 0 || i == WIDTH) f[i] = w[i];
      else f[i] = (int'(w[i-1]) + int'(w[i]) + int'(w[i+1])) >= 2;
    end
    n = 0;
    first = 0;
    for (int i = 1; i <= WIDTH; i++) begin
      if (f[i] != f[i-1]) begin
        if (n == 0) first = i;
        n++;
      end
    end
    hit    = (n > 0);
    pos    = POS_W'(first);
    rising = (n > 0) ? f[first-1] : 1'b0;
    multi  = (n > 1);
  endtask

  task automatic model_reset();
    s1 = '0; s2 = '0;
    exp_valid = 1'b0; exp_pos = '0; exp_rising = 1'b0; exp_multi = 1'b0; exp_drop = '0;
    s_valid = 1'b0; s_drop = '0;
  endtask

  // Event leaving the output register at an edge comes from the word sampled two edges before.
  task automatic model_clock();
    logic hit, rising, multi, new_ev;
    logic [POS_W-1:0] pos;
    if (!resetn) begin
      model_reset();
      return;
    end
    filter_encode(s2, hit, pos, rising, multi);
    new_ev = hit && en;
    if (new_ev) begin
      if (!exp_valid || bus.m_ready) begin
        exp_valid = 1'b1; exp_pos = pos; exp_rising = rising; exp_multi = multi;
      end else if (exp_drop != 16'hFFFF) begin
        exp_drop = exp_drop + 16'd1;
      end
    end else if (exp_valid && bus.m_ready) begin
      exp_valid = 1'b0;
    end
    if (new_ev) begin
      if (!s_valid) s_valid = 1'b1;
      else if (s_drop != 4'hF) s_drop = s_drop + 4'd1;
    end
    s2 = s1;
    s1 = tdc_data;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_clock();
  endtask

  task automatic test_reset();
    resetn = 1'b0; tdc_data = '0; en = 1'b1; bus.m_ready = 1'b1; bus_s.m_ready = 1'b0;
    model_reset();
    #12;
    checks++;
    if ({bus.m_valid, bus.m_pos, bus.m_rising, bus.m_multi, drop_cnt} !== 26'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%h want=0", {bus.m_valid, bus.m_pos, bus.m_rising, bus.m_multi, drop_cnt});
    end
    checks++;
    if ({bus_s.m_valid, drop_small} !== 5'b0) begin
      failures++;
      $display("FAIL reset_small got=%h want=0", {bus_s.m_valid, drop_small});
    end
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_single_events();
    logic [WIDTH:0]   w [5];
    logic [POS_W-1:0] ep [5];
    logic             er [5];
    logic             em [5];
    w[0] = thermo(0, 29);                 ep[0] = 30; er[0] = 1'b1; em[0] = 1'b0;
    w[1] = thermo(0, 29);
    w[1][12] = 1'b0; w[1][70] = 1'b1;     ep[1] = 30; er[1] = 1'b1; em[1] = 1'b0;
    w[2] = thermo(10, 49);                ep[2] = 10; er[2] = 1'b0; em[2] = 1'b1;
    w[3] = thermo(1, WIDTH);              ep[3] = 1;  er[3] = 1'b0; em[3] = 1'b0;
    w[4] = thermo(0, 0);                  ep[4] = 1;  er[4] = 1'b1; em[4] = 1'b0;
    bus.m_ready = 1'b1;
    en = 1'b1;
    for (int c = 0; c < 5; c++) begin
      for (int t = 0; t < 4; t++) begin
        tdc_data = (t == 0) ? w[c] : '0;
        tick();
        checks++;
        if (pack_out(bus.m_valid, bus.m_pos, bus.m_rising, bus.m_multi, drop_cnt) !==
            pack_out(exp_valid, exp_pos, exp_rising, exp_multi, exp_drop)) begin
          failures++;
          $display("FAIL single_model case=%0d t=%0d got v=%b pos=%0d r=%b m=%b want v=%b pos=%0d r=%b m=%b",
                   c, t, bus.m_valid, bus.m_pos, bus.m_rising, bus.m_multi,
                   exp_valid, exp_pos, exp_rising, exp_multi);
        end
        if (t == 2) begin
          checks++;
          if ({bus.m_valid, bus.m_pos, bus.m_rising, bus.m_multi} !== {1'b1, ep[c], er[c], em[c]}) begin
            failures++;
            $display("FAIL single_event case=%0d got v=%b pos=%0d r=%b m=%b want v=1 pos=%0d r=%b m=%b",
                     c, bus.m_valid, bus.m_pos, bus.m_rising, bus.m_multi, ep[c], er[c], em[c]);
          end
        end
      end
    end
  endtask

  task automatic test_no_transition();
    bus.m_ready = 1'b1;
    en = 1'b1;
    for (int t = 0; t < 6; t++) begin
      tdc_data = t[0] ? '1 : '0;
      tick();
      checks++;
      if (bus.m_valid !== 1'b0 || drop_cnt !== 16'd0) begin
        failures++;
        $display("FAIL no_transition t=%0d got v=%b drop=%0d want v=0 drop=0", t, bus.m_valid, drop_cnt);
      end
    end
  endtask

  task automatic test_stall();
    bus.m_ready = 1'b0;
    en = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tdc_data = (c < 10) ? thermo(0, 19 + c) : '0;
      tick();
      checks++;
      if (pack_out(bus.m_valid, bus.m_pos, bus.m_rising, bus.m_multi, drop_cnt) !==
          pack_out(exp_valid, exp_pos, exp_rising, exp_multi, exp_drop)) begin
        failures++;
        $display("FAIL stall_model c=%0d got v=%b pos=%0d drop=%0d want v=%b pos=%0d drop=%0d",
                 c, bus.m_valid, bus.m_pos, drop_cnt, exp_valid, exp_pos, exp_drop);
      end
      if (c >= 2) begin
        checks++;
        if (bus.m_valid !== 1'b1 || bus.m_pos !== 7'd20) begin
          failures++;
          $display("FAIL stall_hold c=%0d got v=%b pos=%0d want v=1 pos=20", c, bus.m_valid, bus.m_pos);
        end
      end
    end
    checks++;
    if (drop_cnt !== 16'd9) begin
      failures++;
      $display("FAIL stall_drops got=%0d want=9", drop_cnt);
    end
    bus.m_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (pack_out(bus.m_valid, bus.m_pos, bus.m_rising, bus.m_multi, drop_cnt) !==
          pack_out(exp_valid, exp_pos, exp_rising, exp_multi, exp_drop)) begin
        failures++;
        $display("FAIL stall_drain c=%0d got v=%b drop=%0d want v=%b drop=%0d",
                 c, bus.m_valid, drop_cnt, exp_valid, exp_drop);
      end
    end
  endtask

  task automatic test_saturation();
    @(negedge clk);
    resetn = 1'b0;
    #1;
    resetn = 1'b1;
    model_reset();
    bus.m_ready = 1'b1;
    en = 1'b1;
    for (int c = 0; c < 22; c++) begin
      tdc_data = thermo(0, 5 + c);
      tick();
      checks++;
      if (drop_small !== s_drop || drop_cnt !== exp_drop) begin
        failures++;
        $display("FAIL saturation c=%0d got small=%0d main=%0d want small=%0d main=%0d",
                 c, drop_small, drop_cnt, s_drop, exp_drop);
      end
    end
    checks++;
    if (drop_small !== 4'd15) begin
      failures++;
      $display("FAIL saturation_cap got=%0d want=15", drop_small);
    end
  endtask

  task automatic test_en_toggle();
    int gaps;
    bus.m_ready = 1'b1;
    en = 1'b1;
    for (int j = 0; j < 3; j++) begin
      tdc_data = thermo(0, 60 + j);
      tick();
    end
    gaps = 0;
    for (int j = 0; j < 6; j++) begin
      tdc_data = thermo(0, 30 + j);
      en = (j == 2) ? 1'b0 : 1'b1;
      tick();
      if (bus.m_valid === 1'b0) gaps++;
      checks++;
      if (pack_out(bus.m_valid, bus.m_pos, bus.m_rising, bus.m_multi, drop_cnt) !==
          pack_out(exp_valid, exp_pos, exp_rising, exp_multi, exp_drop)) begin
        failures++;
        $display("FAIL en_model j=%0d got v=%b pos=%0d want v=%b pos=%0d",
                 j, bus.m_valid, bus.m_pos, exp_valid, exp_pos);
      end
    end
    en = 1'b1;
    checks++;
    if (gaps != 1 || drop_cnt !== 16'd0) begin
      failures++;
      $display("FAIL en_gap got gaps=%0d drop=%0d want gaps=1 drop=0", gaps, drop_cnt);
    end
  endtask

  task automatic test_async_reset();
    bus.m_ready = 1'b0;
    en = 1'b1;
    tdc_data = thermo(0, 40);
    for (int j = 0; j < 3; j++) tick();
    tdc_data = '0;
    checks++;
    if (bus.m_valid !== 1'b1 || exp_valid !== 1'b1) begin
      failures++;
      $display("FAIL async_setup got v=%b want v=1", bus.m_valid);
    end
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if ({bus.m_valid, bus.m_pos, bus.m_rising, bus.m_multi, drop_cnt, bus_s.m_valid, drop_small} !== 31'b0) begin
      failures++;
      $display("FAIL async_clear got=%h want=0",
               {bus.m_valid, bus.m_pos, bus.m_rising, bus.m_multi, drop_cnt, bus_s.m_valid, drop_small});
    end
    #1;
    resetn = 1'b1;
    model_reset();
    bus.m_ready = 1'b1;
    tdc_data = thermo(1, WIDTH);
    for (int e = 1; e <= 3; e++) begin
      tick();
      tdc_data = '0;
      checks++;
      if (e < 3 && bus.m_valid !== 1'b0) begin
        failures++;
        $display("FAIL async_latency edge=%0d got v=%b want v=0", e, bus.m_valid);
      end
      if (e == 3 && {bus.m_valid, bus.m_pos, bus.m_rising, bus.m_multi} !== {1'b1, 7'd1, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL async_first got v=%b pos=%0d r=%b m=%b want v=1 pos=1 r=0 m=0",
                 bus.m_valid, bus.m_pos, bus.m_rising, bus.m_multi);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      tdc_data    = rand_word();
      en          = ($urandom_range(0, 9) != 0);
      bus.m_ready = ($urandom_range(0, 9) < 6);
      tick();
      checks++;
      if (pack_out(bus.m_valid, bus.m_pos, bus.m_rising, bus.m_multi, drop_cnt) !==
          pack_out(exp_valid, exp_pos, exp_rising, exp_multi, exp_drop) || drop_small !== s_drop) begin
        failures++;
        $display("FAIL random n=%0d got v=%b pos=%0d r=%b m=%b drop=%0d sd=%0d want v=%b pos=%0d r=%b m=%b drop=%0d sd=%0d",
                 n, bus.m_valid, bus.m_pos, bus.m_rising, bus.m_multi, drop_cnt, drop_small,
                 exp_valid, exp_pos, exp_rising, exp_multi, exp_drop, s_drop);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_events();
    test_no_transition();
    test_stall();
    test_saturation();
    test_en_toggle();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
